// File: rtl/counter_job_scheduler_if.sv
// counter_job_scheduler_if: requester and counter signals between the job scheduler and its environment
//   req/cancel/start_val/end_val : per-requester job submission (packed, requester i at [i*W +: W])
//   done/aborted/busy/grant_id   : job status back to requesters
//   ctr_load/ctr_enable/ctr_data_in/ctr_count : shared loadable up-counter
interface counter_job_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int W = 8,
  parameter int IDW = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   cancel;
  logic [NUM_REQ*W-1:0] start_val;
  logic [NUM_REQ*W-1:0] end_val;
  logic [NUM_REQ-1:0]   done;
  logic                 aborted;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic                 ctr_load;
  logic                 ctr_enable;
  logic [W-1:0]         ctr_data_in;
  logic [W-1:0]         ctr_count;
  modport slave (
    input  req, cancel, start_val, end_val, ctr_count,
    output done, aborted, busy, grant_id, ctr_load, ctr_enable, ctr_data_in
  );
  modport master (
    output req, cancel, start_val, end_val, ctr_count,
    input  done, aborted, busy, grant_id, ctr_load, ctr_enable, ctr_data_in
  );
endinterface

// File: rtl/counter_job_scheduler.sv
// counter_job_scheduler: round-robin arbiter that runs start->end counting jobs on a shared up-counter
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : counter_job_scheduler_if.slave (requester side and counter side)
module counter_job_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int W = 8,
  parameter int IDW = 2
) (
  input logic clk,
  input logic rst_n,
  counter_job_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state;
  logic [IDW-1:0] ptr, gid, win, cand;
  logic [W-1:0] start_q, end_q;
  logic [W-1:0] sv [NUM_REQ];
  logic [W-1:0] ev [NUM_REQ];
  logic found, hit, cxl, ab_q;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign sv[i] = bus.start_val[i*W +: W];
    assign ev[i] = bus.end_val[i*W +: W];
  end
  // first requester at or after the pointer, wrapping
  always_comb begin
    found = 1'b0;
    win = '0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win = cand;
      end
    end
  end
  assign hit = bus.ctr_count == end_q;
  assign cxl = bus.cancel[gid];
  assign bus.busy = state != IDLE;
  assign bus.grant_id = gid;
  assign bus.ctr_load = state == LOAD;
  assign bus.ctr_data_in = start_q;
  // combinational so the counter stops exactly on end_q; reaching end beats cancel
  assign bus.ctr_enable = state == RUN && !hit && !cxl;
  assign bus.done = state == DONE ? NUM_REQ'(1) << gid : '0;
  assign bus.aborted = state == DONE && ab_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      gid <= '0;
      start_q <= '0;
      end_q <= '0;
      ab_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          gid <= win;
          start_q <= sv[win];
          end_q <= ev[win];
          state <= LOAD;
        end
        LOAD: begin
          ab_q <= 1'b0;
          state <= RUN;
        end
        RUN: if (hit || cxl) begin
          ab_q <= !hit;
          state <= DONE;
        end
        default: begin
          ptr <= gid == IDW'(NUM_REQ - 1) ? '0 : gid + 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_counter_job_scheduler.sv
// tb_counter_job_scheduler: directed self-checking bench with a behavioural 8-bit loadable counter
module tb_counter_job_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  counter_job_scheduler_if #(.NUM_REQ(4), .W(8), .IDW(2)) bus();
  counter_job_scheduler #(.NUM_REQ(4), .W(8), .IDW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [7:0] cnt = 8'h00;
  always @(posedge clk) begin
    if (bus.ctr_load) cnt <= bus.ctr_data_in;
    else if (bus.ctr_enable) cnt <= cnt + 8'h01;
  end
  assign bus.ctr_count = cnt;
  int vec = 0;
  int errs = 0;

  task automatic run_job(input int idx, input logic [7:0] s, input logic [7:0] e, input int cxl_at,
                         input int foreign, output int cyc, output int loads, output int ens,
                         output logic [3:0] dv, output logic ab, output logic [1:0] gid,
                         output logic [7:0] ld, output logic [7:0] fin);
    cyc = 0; loads = 0; ens = 0; dv = '0; ab = 1'b0; gid = '0; ld = '0; fin = '0;
    @(negedge clk);
    bus.start_val[idx*8 +: 8] = s;
    bus.end_val[idx*8 +: 8] = e;
    bus.req[idx] = 1'b1;
    if (foreign >= 0) bus.cancel[foreign] = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      if (c > 1) @(negedge clk);
      if (cxl_at >= 0 && bus.busy && !bus.ctr_load && bus.done == '0 && cnt == cxl_at[7:0])
        bus.cancel[idx] = 1'b1;
      #1;
      if (bus.ctr_load) begin loads++; ld = bus.ctr_data_in; end
      if (bus.ctr_enable) ens++;
      if (bus.done != '0) begin
        cyc = c; dv = bus.done; ab = bus.aborted; gid = bus.grant_id; fin = cnt;
        break;
      end
    end
    bus.req[idx] = 1'b0;
    bus.cancel = '0;
  endtask

  task automatic test_reset();
    #1;
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %0h want 0", bus.busy); end
    vec++; if (bus.done !== 4'h0) begin errs++; $display("FAIL reset_done got %0h want 0", bus.done); end
    vec++; if (bus.aborted !== 1'b0) begin errs++; $display("FAIL reset_aborted got %0h want 0", bus.aborted); end
    vec++; if (bus.grant_id !== 2'd0) begin errs++; $display("FAIL reset_grant got %0h want 0", bus.grant_id); end
    vec++; if (bus.ctr_load !== 1'b0) begin errs++; $display("FAIL reset_load got %0h want 0", bus.ctr_load); end
    vec++; if (bus.ctr_enable !== 1'b0) begin errs++; $display("FAIL reset_enable got %0h want 0", bus.ctr_enable); end
    vec++; if (bus.ctr_data_in !== 8'h00) begin errs++; $display("FAIL reset_data got %0h want 0", bus.ctr_data_in); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int cyc, loads, ens; logic [3:0] dv; logic ab; logic [1:0] gid; logic [7:0] ld, fin;
    run_job(0, 8'h10, 8'h14, -1, -1, cyc, loads, ens, dv, ab, gid, ld, fin);
    vec++; if (loads !== 1) begin errs++; $display("FAIL single_loads got %0d want 1", loads); end
    vec++; if (ld !== 8'h10) begin errs++; $display("FAIL single_load_data got %0h want 10", ld); end
    vec++; if (ens !== 4) begin errs++; $display("FAIL single_enables got %0d want 4", ens); end
    vec++; if (fin !== 8'h14) begin errs++; $display("FAIL single_count got %0h want 14", fin); end
    vec++; if (dv !== 4'b0001) begin errs++; $display("FAIL single_done got %0b want 0001", dv); end
    vec++; if (ab !== 1'b0) begin errs++; $display("FAIL single_aborted got %0h want 0", ab); end
    vec++; if (cyc !== 8) begin errs++; $display("FAIL single_cycles got %0d want 8", cyc); end
  endtask

  task automatic test_wrap();
    int cyc, loads, ens; logic [3:0] dv; logic ab; logic [1:0] gid; logic [7:0] ld, fin;
    run_job(1, 8'hFE, 8'h01, -1, -1, cyc, loads, ens, dv, ab, gid, ld, fin);
    vec++; if (ens !== 3) begin errs++; $display("FAIL wrap_enables got %0d want 3", ens); end
    vec++; if (fin !== 8'h01) begin errs++; $display("FAIL wrap_count got %0h want 01", fin); end
    vec++; if (dv !== 4'b0010) begin errs++; $display("FAIL wrap_done got %0b want 0010", dv); end
    vec++; if (gid !== 2'd1) begin errs++; $display("FAIL wrap_grant got %0d want 1", gid); end
    vec++; if (cyc !== 7) begin errs++; $display("FAIL wrap_cycles got %0d want 7", cyc); end
  endtask

  task automatic test_zero_len();
    int cyc, loads, ens; logic [3:0] dv; logic ab; logic [1:0] gid; logic [7:0] ld, fin;
    run_job(2, 8'h55, 8'h55, -1, -1, cyc, loads, ens, dv, ab, gid, ld, fin);
    vec++; if (ens !== 0) begin errs++; $display("FAIL zero_enables got %0d want 0", ens); end
    vec++; if (loads !== 1) begin errs++; $display("FAIL zero_loads got %0d want 1", loads); end
    vec++; if (cyc !== 4) begin errs++; $display("FAIL zero_cycles got %0d want 4", cyc); end
    vec++; if (dv !== 4'b0100) begin errs++; $display("FAIL zero_done got %0b want 0100", dv); end
    vec++; if (fin !== 8'h55) begin errs++; $display("FAIL zero_count got %0h want 55", fin); end
  endtask

  task automatic test_cancel();
    int cyc, loads, ens; logic [3:0] dv; logic ab; logic [1:0] gid; logic [7:0] ld, fin;
    run_job(3, 8'h20, 8'h2A, 8'h22, -1, cyc, loads, ens, dv, ab, gid, ld, fin);
    vec++; if (ens !== 2) begin errs++; $display("FAIL cancel_enables got %0d want 2", ens); end
    vec++; if (ab !== 1'b1) begin errs++; $display("FAIL cancel_aborted got %0h want 1", ab); end
    vec++; if (fin !== 8'h22) begin errs++; $display("FAIL cancel_count got %0h want 22", fin); end
    vec++; if (dv !== 4'b1000) begin errs++; $display("FAIL cancel_done got %0b want 1000", dv); end
    vec++; if (cyc !== 6) begin errs++; $display("FAIL cancel_cycles got %0d want 6", cyc); end
    run_job(0, 8'h30, 8'h33, -1, 2, cyc, loads, ens, dv, ab, gid, ld, fin);
    vec++; if (ab !== 1'b0) begin errs++; $display("FAIL foreign_aborted got %0h want 0", ab); end
    vec++; if (ens !== 3) begin errs++; $display("FAIL foreign_enables got %0d want 3", ens); end
    vec++; if (fin !== 8'h33) begin errs++; $display("FAIL foreign_count got %0h want 33", fin); end
    vec++; if (dv !== 4'b0001) begin errs++; $display("FAIL foreign_done got %0b want 0001", dv); end
  endtask

  task automatic test_round_robin();
    logic [3:0] one;
    int g;
    bit seen;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.start_val[i*8 +: 8] = 8'(i * 16);
      bus.end_val[i*8 +: 8] = 8'(i * 16 + 1);
    end
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      g = j % 4;
      one = 4'b0001 << g;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(negedge clk); #1;
        seen = bus.done != '0;
      end
      vec++; if (bus.done !== one) begin errs++; $display("FAIL rr_done_%0d got %0b want %0b", j, bus.done, one); end
      vec++; if (bus.grant_id !== 2'(g)) begin errs++; $display("FAIL rr_grant_%0d got %0d want %0d", j, bus.grant_id, g); end
      if (j == 4) bus.req = '0;
      else begin
        bus.req[g] = 1'b0;
        @(negedge clk);
        bus.req[g] = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, loads, ens; logic [3:0] dv; logic ab; logic [1:0] gid; logic [7:0] ld, fin;
    bit seen;
    run_job(2, 8'h00, 8'h01, -1, -1, cyc, loads, ens, dv, ab, gid, ld, fin);
    @(negedge clk);
    bus.start_val[2*8 +: 8] = 8'h00; bus.end_val[2*8 +: 8] = 8'h40;
    bus.start_val[3*8 +: 8] = 8'h00; bus.end_val[3*8 +: 8] = 8'h40;
    bus.req = 4'b1100;
    repeat (6) @(negedge clk);
    #1;
    vec++; if (bus.grant_id !== 2'd3) begin errs++; $display("FAIL mid_pre_grant got %0d want 3", bus.grant_id); end
    vec++; if (bus.ctr_enable !== 1'b1) begin errs++; $display("FAIL mid_pre_enable got %0h want 1", bus.ctr_enable); end
    #1 rst_n = 1'b0;
    #1;
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL mid_busy got %0h want 0", bus.busy); end
    vec++; if (bus.ctr_enable !== 1'b0) begin errs++; $display("FAIL mid_enable got %0h want 0", bus.ctr_enable); end
    vec++; if (bus.grant_id !== 2'd0) begin errs++; $display("FAIL mid_grant got %0d want 0", bus.grant_id); end
    vec++; if (bus.done !== 4'h0) begin errs++; $display("FAIL mid_done got %0b want 0", bus.done); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    vec++; if (bus.grant_id !== 2'd2) begin errs++; $display("FAIL mid_rearb_grant got %0d want 2", bus.grant_id); end
    vec++; if (bus.ctr_load !== 1'b1) begin errs++; $display("FAIL mid_rearb_load got %0h want 1", bus.ctr_load); end
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk); #1;
      seen = bus.done != '0;
    end
    vec++; if (bus.done !== 4'b0100) begin errs++; $display("FAIL mid_final_done got %0b want 0100", bus.done); end
    vec++; if (cnt !== 8'h40) begin errs++; $display("FAIL mid_final_count got %0h want 40", cnt); end
    bus.req = '0;
  endtask

  initial begin
    bus.req = '0;
    bus.cancel = '0;
    bus.start_val = '0;
    bus.end_val = '0;
    test_reset();
    test_single();
    test_wrap();
    test_zero_len();
    test_cancel();
    test_round_robin();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
